// File: rtl/mux_stream_pkg.sv
// Shared channel count, select width and arbitration FSM states for the
// 4-channel stream mux and its 1-to-4 demux counterpart.
package mux_stream_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  function automatic logic [N_CH-1:0] ch_onehot(input logic [SEL_W-1:0] ch);
    ch_onehot     = '0;
    ch_onehot[ch] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_4.sv
// Combinational 4-way round-robin pick, searching from last_grant+1 upward.
// Zero latency; grant_vld is low when no request is present.
module rr_arbiter_4
  import mux_stream_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last_grant,
  output logic [SEL_W-1:0] grant_idx,
  output logic             grant_vld
);

  logic [SEL_W-1:0] cand;

  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    cand      = '0;
    // i == N_CH wraps back onto last_grant itself, giving it lowest priority
    for (int i = 1; i <= N_CH; i++) begin
      cand = last_grant + SEL_W'(i);
      if (!grant_vld && req[cand]) begin
        grant_idx = cand;
        grant_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_4to1_rr_stream.sv
// 4-to-1 round-robin stream merge with optional packet lock; one registered stage,
// 1-cycle latency, 1 beat/cycle, in_ready drops while the output register is stalled.
module mux_4to1_rr_stream
  import mux_stream_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter bit LOCK_ON_LAST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_CH*DATA_W-1:0] in_data,
  input  logic [N_CH-1:0]        in_valid,
  input  logic [N_CH-1:0]        in_last,
  output logic [N_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   out_last,
  output logic [SEL_W-1:0]       out_sel,
  input  logic                   out_ready
);

  state_t           state;
  state_t           state_nxt;
  logic [SEL_W-1:0] lock_ch;
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] winner;
  logic [N_CH-1:0]  req;
  logic             win_vld;
  logic             load;
  logic             accept;
  logic [DATA_W-1:0] ch_data [N_CH];

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      ch_data[k] = in_data[k*DATA_W +: DATA_W];
    end
  end

  // While locked only the owning channel may compete
  assign req = (state == ST_LOCKED) ? (in_valid & ch_onehot(lock_ch)) : in_valid;

  rr_arbiter_4 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .grant_idx  (winner),
    .grant_vld  (win_vld)
  );

  assign load = out_ready || !out_valid;
  // Ready is held low in reset so no upstream beat is consumed on a reset edge
  assign accept   = rst_n && load && win_vld;
  assign in_ready = accept ? ch_onehot(winner) : '0;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept && LOCK_ON_LAST && !in_last[winner]) state_nxt = ST_LOCKED;
      ST_LOCKED: if (accept && in_last[lock_ch]) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= SEL_W'(N_CH-1);
      lock_ch    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_sel    <= '0;
    end else if (accept) begin
      last_grant <= winner;
      if (state == ST_IDLE) lock_ch <= winner;
      out_valid  <= 1'b1;
      out_data   <= ch_data[winner];
      out_last   <= in_last[winner];
      out_sel    <= winner;
    end else if (load) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_4to1_rr_stream.sv
// Bench for mux_4to1_rr_stream: a locking instance and a per-beat round-robin
// instance share stimulus; expected beats are queued at drive time and popped on output transfer.
module tb_mux_4to1_rr_stream;

  typedef struct packed {
    logic [1:0] sel;
    logic       last;
    logic [7:0] data;
  } beat_t;

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  l;
    logic [31:0] d;
    logic        ordy;
    logic [3:0]  erdy;
    logic        ov;
  } cyc_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_last;
  logic        out_ready;

  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_sel;

  logic [3:0]  rr_ready;
  logic [7:0]  rr_data;
  logic        rr_valid;
  logic        rr_last;
  logic [1:0]  rr_sel;

  int checks = 0;
  int errors = 0;
  beat_t exp_q[$];
  beat_t rr_q[$];

  always #5 clk = ~clk;

  mux_4to1_rr_stream #(.DATA_W(8), .LOCK_ON_LAST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  mux_4to1_rr_stream #(.DATA_W(8), .LOCK_ON_LAST(1'b0)) dut_rr (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(rr_ready), .out_data(rr_data), .out_valid(rr_valid), .out_last(rr_last),
    .out_sel(rr_sel), .out_ready(out_ready)
  );

  function automatic cyc_t mk(input logic rst, input logic [3:0] v, input logic [3:0] l,
                              input logic [31:0] d, input logic o, input logic [3:0] erdy,
                              input logic ov);
    cyc_t c;
    c.rst = rst; c.v = v; c.l = l; c.d = d; c.ordy = o; c.erdy = erdy; c.ov = ov;
    return c;
  endfunction

  // Beat the bench expects the granted channel to deliver in this cycle
  function automatic beat_t beat_of(input cyc_t c);
    beat_t b;
    b = '0;
    for (int k = 0; k < 4; k++) begin
      if (c.erdy[k]) begin
        b.sel  = 2'(k);
        b.last = c.l[k];
        b.data = c.d[k*8 +: 8];
      end
    end
    return b;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    rr_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 4'hF; in_last = 4'hF; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, out_sel, out_data, out_last} !== 16'h0) begin
        errors++;
        $display("FAIL reset_lock cyc %0d got v=%b rdy=%b sel=%0d data=%h last=%b want all 0",
                 i, out_valid, in_ready, out_sel, out_data, out_last);
      end
      checks++;
      if ({rr_valid, rr_ready, rr_sel, rr_data, rr_last} !== 16'h0) begin
        errors++;
        $display("FAIL reset_rr cyc %0d got v=%b rdy=%b sel=%0d data=%h want all 0",
                 i, rr_valid, rr_ready, rr_sel, rr_data);
      end
    end
  endtask

  task automatic test_fair_rr();
    beat_t got, exp;
    rst_n = 1'b1; in_valid = 4'hF; in_last = 4'h0; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      #1;
      if (i > 0) begin
        checks++;
        got = {rr_sel, rr_last, rr_data};
        exp = rr_q.pop_front();
        if (!rr_valid || got !== exp) begin
          errors++;
          $display("FAIL rr_order beat %0d got v=%b %h want %h", i-1, rr_valid, got, exp);
        end
        checks++;
        got = {out_sel, out_last, out_data};
        exp = exp_q.pop_front();
        if (!out_valid || got !== exp) begin
          errors++;
          $display("FAIL rr_locked beat %0d got v=%b %h want %h", i-1, out_valid, got, exp);
        end
      end
      if (i < 5) begin
        rr_q.push_back({2'(i % 4), 1'b0, 8'(8'hA0 + i % 4)});
        exp_q.push_back({2'd0, 1'b0, 8'hA0});
      end
      @(negedge clk);
    end
  endtask

  task automatic test_packet_lock();
    cyc_t seq[$];
    beat_t got, exp;
    seq.push_back(mk(1, 4'b0110, 4'b0100, 32'h00C2B100, 1, 4'b0010, 0));
    seq.push_back(mk(1, 4'b0110, 4'b0100, 32'h00C2B200, 1, 4'b0010, 1));
    seq.push_back(mk(1, 4'b0110, 4'b0110, 32'h00C2B300, 1, 4'b0010, 1));
    seq.push_back(mk(1, 4'b0100, 4'b0100, 32'h00C20000, 1, 4'b0100, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0));
    foreach (seq[c]) begin
      rst_n = seq[c].rst; in_valid = seq[c].v; in_last = seq[c].l; in_data = seq[c].d;
      out_ready = seq[c].ordy;
      #1;
      checks++;
      if (out_valid !== seq[c].ov) begin
        errors++;
        $display("FAIL lock_valid cyc %0d got %b want %b", c, out_valid, seq[c].ov);
      end
      if (out_valid && out_ready) begin
        checks++;
        got = {out_sel, out_last, out_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL lock_extra cyc %0d got %h want no beat", c, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL lock_beat cyc %0d got %h want %h", c, got, exp);
          end
        end
      end
      checks++;
      if (in_ready !== seq[c].erdy) begin
        errors++;
        $display("FAIL lock_ready cyc %0d got %b want %b", c, in_ready, seq[c].erdy);
      end
      if (seq[c].erdy != 0) exp_q.push_back(beat_of(seq[c]));
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lock_missing got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    cyc_t seq[$];
    beat_t got, exp;
    seq.push_back(mk(1, 4'b1000, 4'b1000, 32'hD0000000, 1, 4'b1000, 0));
    for (int i = 0; i < 4; i++)
      seq.push_back(mk(1, 4'b1000, 4'b1000, 32'hD1000000, 0, 4'b0000, 1));
    seq.push_back(mk(1, 4'b1000, 4'b1000, 32'hD1000000, 1, 4'b1000, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0));
    foreach (seq[c]) begin
      rst_n = seq[c].rst; in_valid = seq[c].v; in_last = seq[c].l; in_data = seq[c].d;
      out_ready = seq[c].ordy;
      #1;
      checks++;
      if (out_valid !== seq[c].ov) begin
        errors++;
        $display("FAIL bp_valid cyc %0d got %b want %b", c, out_valid, seq[c].ov);
      end
      if (out_valid && out_ready) begin
        checks++;
        got = {out_sel, out_last, out_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bp_extra cyc %0d got %h want no beat", c, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL bp_beat cyc %0d got %h want %h", c, got, exp);
          end
        end
      end
      checks++;
      if (in_ready !== seq[c].erdy) begin
        errors++;
        $display("FAIL bp_ready cyc %0d got %b want %b", c, in_ready, seq[c].erdy);
      end
      if (seq[c].erdy != 0) exp_q.push_back(beat_of(seq[c]));
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL bp_missing got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_lock_gap();
    cyc_t seq[$];
    beat_t got, exp;
    seq.push_back(mk(1, 4'b0011, 4'b0010, 32'h0000F1E1, 1, 4'b0001, 0));
    seq.push_back(mk(1, 4'b0011, 4'b0010, 32'h0000F1E2, 1, 4'b0001, 1));
    seq.push_back(mk(1, 4'b0010, 4'b0010, 32'h0000F100, 1, 4'b0000, 1));
    seq.push_back(mk(1, 4'b0010, 4'b0010, 32'h0000F100, 1, 4'b0000, 0));
    seq.push_back(mk(1, 4'b0011, 4'b0011, 32'h0000F1E3, 1, 4'b0001, 0));
    seq.push_back(mk(1, 4'b0010, 4'b0010, 32'h0000F100, 1, 4'b0010, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0));
    foreach (seq[c]) begin
      rst_n = seq[c].rst; in_valid = seq[c].v; in_last = seq[c].l; in_data = seq[c].d;
      out_ready = seq[c].ordy;
      #1;
      checks++;
      if (out_valid !== seq[c].ov) begin
        errors++;
        $display("FAIL gap_valid cyc %0d got %b want %b", c, out_valid, seq[c].ov);
      end
      if (out_valid && out_ready) begin
        checks++;
        got = {out_sel, out_last, out_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL gap_extra cyc %0d got %h want no beat", c, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL gap_beat cyc %0d got %h want %h", c, got, exp);
          end
        end
      end
      checks++;
      if (in_ready !== seq[c].erdy) begin
        errors++;
        $display("FAIL gap_ready cyc %0d got %b want %b", c, in_ready, seq[c].erdy);
      end
      if (seq[c].erdy != 0) exp_q.push_back(beat_of(seq[c]));
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL gap_missing got %0d beats left want 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_packet();
    cyc_t seq[$];
    beat_t got, exp;
    seq.push_back(mk(1, 4'b0100, 4'b0000, 32'h00470000, 1, 4'b0100, 0));
    seq.push_back(mk(0, 4'b0100, 4'b0000, 32'h00480000, 1, 4'b0000, 1));
    seq.push_back(mk(1, 4'b0101, 4'b0001, 32'h00480050, 1, 4'b0001, 0));
    seq.push_back(mk(1, 4'b0100, 4'b0000, 32'h00480000, 1, 4'b0100, 1));
    seq.push_back(mk(1, 4'b0100, 4'b0100, 32'h00490000, 1, 4'b0100, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 1));
    seq.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 1, 4'b0000, 0));
    foreach (seq[c]) begin
      rst_n = seq[c].rst; in_valid = seq[c].v; in_last = seq[c].l; in_data = seq[c].d;
      out_ready = seq[c].ordy;
      #1;
      checks++;
      if (out_valid !== seq[c].ov) begin
        errors++;
        $display("FAIL rstpkt_valid cyc %0d got %b want %b", c, out_valid, seq[c].ov);
      end
      if (out_valid && out_ready) begin
        checks++;
        got = {out_sel, out_last, out_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rstpkt_extra cyc %0d got %h want no beat", c, got);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL rstpkt_beat cyc %0d got %h want %h", c, got, exp);
          end
        end
      end
      checks++;
      if (in_ready !== seq[c].erdy) begin
        errors++;
        $display("FAIL rstpkt_ready cyc %0d got %b want %b", c, in_ready, seq[c].erdy);
      end
      if (seq[c].erdy != 0) exp_q.push_back(beat_of(seq[c]));
      if (!seq[c].rst) exp_q.delete();
      @(negedge clk);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rstpkt_missing got %0d beats left want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_fair_rr();
    do_reset();
    test_packet_lock();
    do_reset();
    test_backpressure();
    do_reset();
    test_lock_gap();
    do_reset();
    test_reset_mid_packet();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got no end of test want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
